// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter: shares the GPR write port between CSR, FPU and ALU producers.
// One holding slot per source, fixed priority with starvation promotion.
module gpr_wb_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = 4,
    parameter int STARVE_W     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              csr_vld,
    output logic              csr_rdy,
    input  logic [ADDR_W-1:0] csr_addr,
    input  logic [DATA_W-1:0] csr_data,
    input  logic              fpu_vld,
    output logic              fpu_rdy,
    input  logic [ADDR_W-1:0] fpu_addr,
    input  logic [DATA_W-1:0] fpu_data,
    input  logic              alu_vld,
    output logic              alu_rdy,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    output logic              gpr_wen,
    output logic [ADDR_W-1:0] gpr_waddr,
    output logic [DATA_W-1:0] gpr_wdata,
    output logic [2:0]        gpr_grant,
    output logic [31:0]       pend_mask
);

    localparam int N = 3;
    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    logic [N-1:0]        in_vld;
    logic [ADDR_W-1:0]   in_addr [N];
    logic [DATA_W-1:0]   in_data [N];

    logic [N-1:0]        slot_vld_q, slot_vld_d;
    logic [ADDR_W-1:0]   slot_addr_q [N];
    logic [ADDR_W-1:0]   slot_addr_d [N];
    logic [DATA_W-1:0]   slot_data_q [N];
    logic [DATA_W-1:0]   slot_data_d [N];
    logic [STARVE_W-1:0] starve_q [N];
    logic [STARVE_W-1:0] starve_d [N];

    logic [N-1:0]        promo;
    logic [N-1:0]        cand;
    logic [N-1:0]        grant;
    logic [N-1:0]        rdy;
    logic [N-1:0]        accept;

    assign in_vld     = {alu_vld, fpu_vld, csr_vld};
    assign in_addr[0] = csr_addr;
    assign in_addr[1] = fpu_addr;
    assign in_addr[2] = alu_addr;
    assign in_data[0] = csr_data;
    assign in_data[1] = fpu_data;
    assign in_data[2] = alu_data;

    // Arbitration from slot state only: promoted slots first, then lowest index.
    always_comb begin
        promo = '0;
        for (int i = 0; i < N; i++) begin
            promo[i] = slot_vld_q[i] && (starve_q[i] == LIMIT);
        end
        cand  = (|promo) ? promo : slot_vld_q;
        grant = cand & (~cand + 3'd1);
    end

    // A slot can take a new entry when empty or when its entry leaves this cycle.
    always_comb begin
        rdy    = ~slot_vld_q | grant;
        accept = in_vld & rdy;
    end

    assign csr_rdy   = rdy[0];
    assign fpu_rdy   = rdy[1];
    assign alu_rdy   = rdy[2];
    assign gpr_grant = grant;

    // Write port mux and pending-destination mask.
    always_comb begin
        gpr_wen   = |grant;
        gpr_waddr = '0;
        gpr_wdata = '0;
        pend_mask = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                gpr_waddr = slot_addr_q[i];
                gpr_wdata = slot_data_q[i];
            end
            if (slot_vld_q[i]) begin
                pend_mask = pend_mask | (32'd1 << slot_addr_q[i]);
            end
        end
        pend_mask[0] = 1'b0;
    end

    // Slot load/drain and saturating starvation count.
    always_comb begin
        slot_vld_d = slot_vld_q;
        for (int i = 0; i < N; i++) begin
            slot_addr_d[i] = slot_addr_q[i];
            slot_data_d[i] = slot_data_q[i];
            starve_d[i]    = starve_q[i];
            if (accept[i]) begin
                slot_vld_d[i]  = (in_addr[i] != '0);
                slot_addr_d[i] = in_addr[i];
                slot_data_d[i] = in_data[i];
                starve_d[i]    = '0;
            end else if (grant[i] || !slot_vld_q[i]) begin
                slot_vld_d[i]  = 1'b0;
                starve_d[i]    = '0;
            end else if (starve_q[i] != LIMIT) begin
                starve_d[i]    = starve_q[i] + 1'b1;
            end
        end
    end

    // Slot registers; reset drops every held write.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_vld_q <= '0;
            for (int i = 0; i < N; i++) begin
                slot_addr_q[i] <= '0;
                slot_data_q[i] <= '0;
                starve_q[i]    <= '0;
            end
        end else begin
            slot_vld_q <= slot_vld_d;
            for (int i = 0; i < N; i++) begin
                slot_addr_q[i] <= slot_addr_d[i];
                slot_data_q[i] <= slot_data_d[i];
                starve_q[i]    <= starve_d[i];
            end
        end
    end

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// tb_gpr_wb_arbiter: directed scenario tasks for gpr_wb_arbiter.
// Inputs driven 1ns after posedge; outputs sampled there too.
module tb_gpr_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_vld, fpu_vld, alu_vld;
    logic        csr_rdy, fpu_rdy, alu_rdy;
    logic [4:0]  csr_addr, fpu_addr, alu_addr;
    logic [31:0] csr_data, fpu_data, alu_data;
    logic        gpr_wen;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    logic [2:0]  gpr_grant;
    logic [31:0] pend_mask;

    int checks   = 0;
    int failures = 0;

    gpr_wb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .csr_vld   (csr_vld),
        .csr_rdy   (csr_rdy),
        .csr_addr  (csr_addr),
        .csr_data  (csr_data),
        .fpu_vld   (fpu_vld),
        .fpu_rdy   (fpu_rdy),
        .fpu_addr  (fpu_addr),
        .fpu_data  (fpu_data),
        .alu_vld   (alu_vld),
        .alu_rdy   (alu_rdy),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .gpr_wen   (gpr_wen),
        .gpr_waddr (gpr_waddr),
        .gpr_wdata (gpr_wdata),
        .gpr_grant (gpr_grant),
        .pend_mask (pend_mask)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        csr_vld = 1'b1; csr_addr = 5'd1; csr_data = 32'h11;
        fpu_vld = 1'b1; fpu_addr = 5'd2; fpu_data = 32'h22;
        alu_vld = 1'b1; alu_addr = 5'd7; alu_data = 32'h77;
        tick();
        tick();
        checks++;
        if ({csr_rdy, fpu_rdy, alu_rdy} !== 3'b111) begin
            failures++;
            $display("FAIL reset_rdy got=%b exp=111", {csr_rdy, fpu_rdy, alu_rdy});
        end
        checks++;
        if (gpr_wen !== 1'b0 || pend_mask !== 32'h0) begin
            failures++;
            $display("FAIL reset_wen_pend got wen=%b pend=%h exp 0/0", gpr_wen, pend_mask);
        end
        rst = 1'b0;
        checks++;
        if (gpr_wen !== 1'b0) begin
            failures++;
            $display("FAIL reset_fall_wen got=%b exp=0", gpr_wen);
        end
        tick();
        csr_vld = 1'b0; fpu_vld = 1'b0; alu_vld = 1'b0;
        checks++;
        if (gpr_wen !== 1'b1 || gpr_waddr !== 5'd1 || gpr_wdata !== 32'h11 ||
            gpr_grant !== 3'b001) begin
            failures++;
            $display("FAIL first_write got wen=%b a=%0d d=%h g=%b exp 1/1/11/001",
                     gpr_wen, gpr_waddr, gpr_wdata, gpr_grant);
        end
        checks++;
        if (pend_mask !== 32'h86) begin
            failures++;
            $display("FAIL first_pend got=%h exp=00000086", pend_mask);
        end
        tick();
        checks++;
        if (gpr_waddr !== 5'd2 || gpr_grant !== 3'b010) begin
            failures++;
            $display("FAIL drain_fpu got a=%0d g=%b exp 2/010", gpr_waddr, gpr_grant);
        end
        tick();
        checks++;
        if (gpr_waddr !== 5'd7 || gpr_wdata !== 32'h77 || gpr_grant !== 3'b100) begin
            failures++;
            $display("FAIL drain_alu got a=%0d d=%h g=%b exp 7/77/100",
                     gpr_waddr, gpr_wdata, gpr_grant);
        end
        tick();
        checks++;
        if (gpr_wen !== 1'b0 || gpr_waddr !== 5'd0 || gpr_wdata !== 32'h0) begin
            failures++;
            $display("FAIL drain_idle got wen=%b a=%0d d=%h exp 0/0/0",
                     gpr_wen, gpr_waddr, gpr_wdata);
        end
    endtask

    task automatic test_single();
        alu_vld = 1'b1; alu_addr = 5'd5; alu_data = 32'h0000_1234;
        tick();
        alu_vld = 1'b0;
        checks++;
        if (gpr_wen !== 1'b1 || gpr_waddr !== 5'd5 || gpr_wdata !== 32'h1234 ||
            gpr_grant !== 3'b100) begin
            failures++;
            $display("FAIL single_write got wen=%b a=%0d d=%h g=%b exp 1/5/1234/100",
                     gpr_wen, gpr_waddr, gpr_wdata, gpr_grant);
        end
        checks++;
        if (pend_mask !== 32'h20) begin
            failures++;
            $display("FAIL single_pend got=%h exp=00000020", pend_mask);
        end
        tick();
        checks++;
        if (pend_mask !== 32'h0 || gpr_wen !== 1'b0) begin
            failures++;
            $display("FAIL single_after got pend=%h wen=%b exp 0/0", pend_mask, gpr_wen);
        end
    endtask

    task automatic test_collision();
        csr_vld = 1'b1; csr_addr = 5'd3; csr_data = 32'hA;
        fpu_vld = 1'b1; fpu_addr = 5'd4; fpu_data = 32'hB;
        alu_vld = 1'b1; alu_addr = 5'd6; alu_data = 32'hC;
        tick();
        csr_vld = 1'b0; fpu_vld = 1'b0; alu_vld = 1'b0;
        checks++;
        if (gpr_waddr !== 5'd3 || gpr_wdata !== 32'hA || gpr_grant !== 3'b001 ||
            alu_rdy !== 1'b0 || pend_mask !== 32'h58) begin
            failures++;
            $display("FAIL coll_c1 got a=%0d d=%h g=%b ardy=%b pend=%h exp 3/A/001/0/58",
                     gpr_waddr, gpr_wdata, gpr_grant, alu_rdy, pend_mask);
        end
        tick();
        checks++;
        if (gpr_waddr !== 5'd4 || gpr_wdata !== 32'hB || gpr_grant !== 3'b010 ||
            alu_rdy !== 1'b0 || pend_mask !== 32'h50) begin
            failures++;
            $display("FAIL coll_c2 got a=%0d d=%h g=%b ardy=%b pend=%h exp 4/B/010/0/50",
                     gpr_waddr, gpr_wdata, gpr_grant, alu_rdy, pend_mask);
        end
        tick();
        checks++;
        if (gpr_waddr !== 5'd6 || gpr_wdata !== 32'hC || gpr_grant !== 3'b100 ||
            alu_rdy !== 1'b1) begin
            failures++;
            $display("FAIL coll_c3 got a=%0d d=%h g=%b ardy=%b exp 6/C/100/1",
                     gpr_waddr, gpr_wdata, gpr_grant, alu_rdy);
        end
        tick();
        checks++;
        if (gpr_wen !== 1'b0) begin
            failures++;
            $display("FAIL coll_idle got wen=%b exp=0", gpr_wen);
        end
    endtask

    task automatic test_starvation();
        alu_vld = 1'b1; alu_addr = 5'd9;  alu_data = 32'h99;
        csr_vld = 1'b1; csr_addr = 5'd10; csr_data = 32'h100;
        tick();
        alu_vld = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (gpr_grant !== 3'b001 || gpr_waddr !== 5'd10 ||
                gpr_wdata !== 32'h100 + 32'(k - 1) || csr_rdy !== 1'b1) begin
                failures++;
                $display("FAIL starve_csr%0d got g=%b a=%0d d=%h rdy=%b exp 001/10/%h/1",
                         k, gpr_grant, gpr_waddr, gpr_wdata, csr_rdy,
                         32'h100 + 32'(k - 1));
            end
            csr_data = 32'h100 + 32'(k);
            tick();
        end
        csr_vld = 1'b0;
        checks++;
        if (gpr_grant !== 3'b100 || gpr_waddr !== 5'd9 || gpr_wdata !== 32'h99 ||
            csr_rdy !== 1'b0) begin
            failures++;
            $display("FAIL starve_promote got g=%b a=%0d d=%h crdy=%b exp 100/9/99/0",
                     gpr_grant, gpr_waddr, gpr_wdata, csr_rdy);
        end
        tick();
        checks++;
        if (gpr_grant !== 3'b001 || gpr_wdata !== 32'h104) begin
            failures++;
            $display("FAIL starve_resume got g=%b d=%h exp 001/104", gpr_grant, gpr_wdata);
        end
        tick();
        checks++;
        if (gpr_wen !== 1'b0 || pend_mask !== 32'h0) begin
            failures++;
            $display("FAIL starve_idle got wen=%b pend=%h exp 0/0", gpr_wen, pend_mask);
        end
    endtask

    task automatic test_x0_drop();
        fpu_vld = 1'b1; fpu_addr = 5'd0; fpu_data = 32'hDEAD_BEEF;
        checks++;
        if (fpu_rdy !== 1'b1) begin
            failures++;
            $display("FAIL x0_rdy got=%b exp=1", fpu_rdy);
        end
        tick();
        fpu_vld = 1'b0;
        checks++;
        if (gpr_wen !== 1'b0 || pend_mask !== 32'h0 || fpu_rdy !== 1'b1) begin
            failures++;
            $display("FAIL x0_drop got wen=%b pend=%h rdy=%b exp 0/0/1",
                     gpr_wen, pend_mask, fpu_rdy);
        end
        tick();
        checks++;
        if (gpr_wen !== 1'b0) begin
            failures++;
            $display("FAIL x0_late got wen=%b exp=0", gpr_wen);
        end
    endtask

    task automatic test_reset_midop();
        csr_vld = 1'b1; csr_addr = 5'd11; csr_data = 32'h1;
        fpu_vld = 1'b1; fpu_addr = 5'd12; fpu_data = 32'h2;
        alu_vld = 1'b1; alu_addr = 5'd13; alu_data = 32'h3;
        tick();
        csr_vld = 1'b0; fpu_vld = 1'b0; alu_vld = 1'b0;
        checks++;
        if (pend_mask !== 32'h3800) begin
            failures++;
            $display("FAIL midop_pend got=%h exp=00003800", pend_mask);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (pend_mask !== 32'h0 || {csr_rdy, fpu_rdy, alu_rdy} !== 3'b111) begin
            failures++;
            $display("FAIL midop_rst got pend=%h rdy=%b exp 0/111",
                     pend_mask, {csr_rdy, fpu_rdy, alu_rdy});
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (gpr_wen !== 1'b0 || gpr_grant !== 3'b000) begin
                failures++;
                $display("FAIL midop_wen%0d got wen=%b g=%b exp 0/000",
                         k, gpr_wen, gpr_grant);
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        csr_vld = 1'b0; fpu_vld = 1'b0; alu_vld = 1'b0;
        csr_addr = '0; fpu_addr = '0; alu_addr = '0;
        csr_data = '0; fpu_data = '0; alu_data = '0;
        #1;
        test_reset();
        test_single();
        test_collision();
        test_starvation();
        test_x0_drop();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
